// File: rtl/cla28_pipe_pkg.sv
// ============================================================================
//  Module      : cla28_pipe_pkg
//  Description : Shared width constants and pipe-stage payload records for
//                the two-stage 28-bit carry-lookahead adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla28_pipe_pkg;

    localparam int C_W    = 28;
    localparam int C_HALF = C_W / 2;

    // Stage 1: finished low half plus the raw high operands still to be added
    typedef struct packed {
        logic [C_HALF-1:0] lo_sum;
        logic              lo_cout;
        logic [C_HALF-1:0] a_hi;
        logic [C_HALF-1:0] b_hi;
    } s1_payload_t;

    typedef struct packed {
        logic [C_W-1:0] sum;
        logic           cout;
    } s2_payload_t;

    typedef struct packed {
        logic [C_W-1:0] a;
        logic [C_W-1:0] b;
        logic           cin;
    } shadow_t;

endpackage

`default_nettype wire

// File: rtl/cla28_pipe_cla_half.sv
// ============================================================================
//  Module      : cla_half
//  Description : Combinational N-bit carry-lookahead adder (generate/propagate).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_half #(
    parameter int N = 14
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N:0]   w_c;
    logic         w_term;
    logic         w_prop;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is the flattened lookahead sum-of-products, never c[i] itself
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        w_prop = 1'b0;
        w_c[0] = cin;
        for (int i = 0; i < N; i++) begin
            w_term = w_g[i];
            w_prop = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_term = w_term | (w_prop & w_g[j]);
                w_prop = w_prop & w_p[j];
            end
            w_c[i+1] = w_term | (w_prop & cin);
        end
    end

    assign sum  = w_p ^ w_c[N-1:0];
    assign cout = w_c[N];

endmodule

`default_nettype wire

// File: rtl/cla28_pipe.sv
// ============================================================================
//  Module      : cla28_pipe
//  Description : Two-stage valid/ready pipelined W-bit adder built from two
//                W/2-bit carry-lookahead halves. Optional self-check enabled
//                by defining CLA28_PIPE_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla28_pipe
    import cla28_pipe_pkg::*;
#(
    parameter int W = C_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         err
);

    localparam int HW = W / 2;

    logic [HW-1:0] w_lo_sum;
    logic          w_lo_cout;
    logic [HW-1:0] w_hi_sum;
    logic          w_hi_cout;
    logic          w_s2_take;
    logic          w_in_fire;

    s1_payload_t   r_s1;
    logic          r_s1_valid;
    s2_payload_t   r_s2;
    logic          r_s2_valid;

    // Stage 2 can accept when empty or when its current result drains now
    assign w_s2_take = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_take;
    assign w_in_fire = in_valid && in_ready;

    cla_half #(.N(HW)) u_lo (
        .a    (a[HW-1:0]),
        .b    (b[HW-1:0]),
        .cin  (cin),
        .sum  (w_lo_sum),
        .cout (w_lo_cout)
    );

    cla_half #(.N(HW)) u_hi (
        .a    (r_s1.a_hi),
        .b    (r_s1.b_hi),
        .cin  (r_s1.lo_cout),
        .sum  (w_hi_sum),
        .cout (w_hi_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_fire) begin
                r_s1.lo_sum  <= w_lo_sum;
                r_s1.lo_cout <= w_lo_cout;
                r_s1.a_hi    <= a[W-1:HW];
                r_s1.b_hi    <= b[W-1:HW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_take) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2.sum  <= {w_hi_sum, r_s1.lo_sum};
                r_s2.cout <= w_hi_cout;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign sum       = r_s2.sum;
    assign cout      = r_s2.cout;

`ifdef CLA28_PIPE_CHECK_EN
    shadow_t       r_s1_sh;
    shadow_t       r_s2_sh;
    logic          r_err;
    logic          w_move;
    logic [W:0]    w_ref;

    assign w_move = r_s1_valid && w_s2_take;
    assign w_ref  = {1'b0, r_s2_sh.a} + {1'b0, r_s2_sh.b} + {{W{1'b0}}, r_s2_sh.cin};

    // Shadow operands ride alongside the payload so each result can be re-added
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_sh <= '0;
            r_s2_sh <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_sh.a   <= a;
                r_s1_sh.b   <= b;
                r_s1_sh.cin <= cin;
            end
            if (w_move) begin
                r_s2_sh <= r_s1_sh;
            end
            if (r_s2_valid && out_ready && ({r_s2.cout, r_s2.sum} != w_ref)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla28_pipe.sv
// ============================================================================
//  Module      : tb_cla28_pipe
//  Description : Self-checking bench for cla28_pipe with a queue-based
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla28_pipe;

    localparam int W = 28;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int           n_checks;
    int           n_errors;
    logic [W:0]   q[$];
    logic         acc;
    logic         skip_sb;
    int           n_acc;
    int           idx;
    logic [W-1:0] held;
    logic [W:0]   exp_v;
    logic [W-1:0] bp_a[4];
    logic [W-1:0] bp_b[4];
    logic         bp_c[4];

    cla28_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        longint s;
        s = longint'(x) + longint'(y) + longint'(c);
        return s[W:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = c;
    endtask

    // One clock: handshakes are judged at the negedge, then advance past the posedge
    task automatic cycle(output logic accepted);
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                exp_v = q.pop_front();
                if (!skip_sb) chk("result", 64'({cout, sum}), 64'(exp_v));
            end
        end
        if (accepted) q.push_back(model_add(a, b, cin));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        skip_sb   = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All-ones + 1 wraps, two-cycle latency
        drive(1'b1, 28'hFFFFFFF, 28'h0000001, 1'b0);
        cycle(acc);
        chk("wrap_accept", 64'(acc), 64'(1));
        chk("wrap_lat1_valid", 64'(out_valid), 64'(0));
        drive(1'b0, '0, '0, 1'b0);
        cycle(acc);
        chk("wrap_lat2_valid", 64'(out_valid), 64'(1));
        chk("wrap_sum", 64'(sum), 64'(0));
        chk("wrap_cout", 64'(cout), 64'(1));
        cycle(acc);

        // Carry crossing the half boundary
        drive(1'b1, 28'h0003FFF, 28'h0000001, 1'b0);
        cycle(acc);
        drive(1'b0, '0, '0, 1'b0);
        cycle(acc);
        chk("cross_sum", 64'(sum), 64'(28'h0004000));
        chk("cross_cout", 64'(cout), 64'(0));
        cycle(acc);

        // Back-to-back stream
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 28'hFFFFFFF, W'(i), 1'b0);
            cycle(acc);
            chk("stream_accept", 64'(acc), 64'(1));
            if (i >= 1) chk("stream_no_bubble", 64'(out_valid), 64'(1));
        end
        drive(1'b0, '0, '0, 1'b0);
        cycle(acc);
        cycle(acc);
        chk("stream_drained", 64'(q.size()), 64'(0));

        // Backpressure: five stalled cycles then release
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = W'($urandom);
            bp_b[i] = W'($urandom);
            bp_c[i] = 1'($urandom);
        end
        out_ready = 1'b0;
        n_acc     = 0;
        held      = '0;
        for (int c = 0; c < 5; c++) begin
            idx = (n_acc < 4) ? n_acc : 0;
            drive(n_acc < 4, bp_a[idx], bp_b[idx], bp_c[idx]);
            cycle(acc);
            if (acc) n_acc++;
            if (c == 1) held = sum;
            if (c >= 2) begin
                chk("bp_in_ready_low", 64'(in_ready), 64'(0));
                chk("bp_out_valid", 64'(out_valid), 64'(1));
                chk("bp_sum_held", 64'(sum), 64'(held));
            end
        end
        chk("bp_accepts_stalled", 64'(n_acc), 64'(2));
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (n_acc < 4 || q.size() > 0); c++) begin
            idx = (n_acc < 4) ? n_acc : 0;
            drive(n_acc < 4, bp_a[idx], bp_b[idx], bp_c[idx]);
            cycle(acc);
            if (acc) n_acc++;
        end
        chk("bp_all_accepted", 64'(n_acc), 64'(4));
        chk("bp_drained", 64'(q.size()), 64'(0));

        // Reset with both stages full
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
            cycle(acc);
        end
        chk("mid_full_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        cycle(acc);
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        q.delete();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(acc);
            chk("mid_no_ghost", 64'(out_valid), 64'(0));
        end

        // Random traffic with occasional all-ones operands
        for (int i = 0; i < 1000; i++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? '1 : W'($urandom),
                  ($urandom_range(0, 7) == 0) ? '1 : W'($urandom),
                  1'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            cycle(acc);
        end
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) cycle(acc);
        chk("rand_drained", 64'(q.size()), 64'(0));
        chk("rand_err_clear", 64'(err), 64'(0));

`ifdef CLA28_PIPE_CHECK_EN
        // Corrupt a held stage-2 result and let it transfer
        out_ready = 1'b0;
        drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        cycle(acc);
        drive(1'b0, '0, '0, 1'b0);
        cycle(acc);
        exp_v = q[0];
        force dut.r_s2 = {exp_v[W-1:0] ^ 28'h0000001, exp_v[W]};
        out_ready = 1'b1;
        skip_sb   = 1'b1;
        cycle(acc);
        release dut.r_s2;
        skip_sb = 1'b0;
        chk("chk_err_set", 64'(err), 64'(1));
        for (int i = 0; i < 3; i++) cycle(acc);
        chk("chk_err_sticky", 64'(err), 64'(1));
        rst = 1'b1;
        cycle(acc);
        rst = 1'b0;
        chk("chk_err_cleared", 64'(err), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cla28_pipe.md
CLA28_PIPE -- requirements
Module: cla28_pipe

Interface
REQ-001 Parameter: W, 28, operand/sum width; SHALL be even; low half = W/2 bits, high half = W/2 bits.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand set a/b/cin is valid this cycle.
REQ-005 Port: in_ready  output  1  block accepts operands this cycle.
REQ-006 Port: a  input  W  operand A, unsigned.
REQ-007 Port: b  input  W  operand B, unsigned.
REQ-008 Port: cin  input  1  carry-in.
REQ-009 Port: out_valid  output  1  sum/cout valid.
REQ-010 Port: out_ready  input  1  consumer accepts result this cycle.
REQ-011 Port: sum  output  W  (a + b + cin) mod 2^W.
REQ-012 Port: cout  output  1  carry out of bit W-1.
REQ-013 Port: err  output  1  sticky self-check mismatch flag.

Function
REQ-014 Transfer occurs on a cycle only when valid and ready are both high; valid SHALL NOT depend combinationally on ready.
REQ-015 Stage 1 SHALL register the low-half sum, the low-half carry-out, and the high halves of a/b on an input transfer.
REQ-016 Stage 2 SHALL register the high-half sum from the registered high operands plus the registered low carry, and SHALL drive sum/cout/out_valid from its registers.
REQ-017 Latency SHALL be exactly 2 cycles: an input accepted at edge N is presented with out_valid=1 after edge N+1 when the pipe is not stalled.
REQ-018 Throughput SHALL be one result per cycle while out_ready=1.
REQ-019 in_ready = !s1_valid || !s2_valid || out_ready; each stage SHALL advance only when the next stage is empty or draining in the same cycle.
REQ-020 When stalled (out_valid=1, out_ready=0), sum/cout/out_valid and stage-1 contents SHALL remain stable; no result is dropped or duplicated.
REQ-021 Simultaneous input accept, stage-1 to stage-2 move, and output drain in one cycle SHALL be supported with no bubble.
REQ-022 Wrap-around: all-ones + 1 SHALL yield sum=0, cout=1; there is no saturation.
REQ-023 Low-half carry SHALL propagate to the high half exactly as in a flat W-bit addition.

Reset
REQ-024 With rst=1 at a clock edge, s1_valid, s2_valid, out_valid, sum, cout and err SHALL be 0 after that edge; in_ready SHALL be 1 after that edge.
REQ-025 Reset mid-operation SHALL discard all in-flight operands; no result SHALL appear afterwards for them.

Configuration
REQ-026 Macro CLA28_PIPE_CHECK_EN: when defined, operands SHALL be carried alongside the pipe, a behavioural a+b+cin SHALL be compared to {cout,sum} on every output transfer, and err SHALL set on mismatch and hold until rst.
REQ-027 Without CLA28_PIPE_CHECK_EN, err SHALL be tied to 0 and no shadow operand registers SHALL exist.

Structure
REQ-028 A shared package SHALL hold the width constant (28), the half width, and the pipe-stage payload record types.
REQ-029 One sub-module cla_half SHALL be instantiated twice: a W/2-bit carry-lookahead adder (generate/propagate, carry-in, sum, carry-out), purely combinational.

Verification
REQ-030 a=0xFFFFFFF, b=0x0000001, cin=0, out_ready=1 -> 2 cycles later sum=0x0000000, cout=1, out_valid=1.
REQ-031 a=0x0003FFF, b=0x0000001, cin=0 -> sum=0x0004000, cout=0 (low-to-high carry crossing).
REQ-032 Streaming: a=0xFFFFFFF, b=i for i=0..15 on consecutive cycles, out_ready=1 -> 16 back-to-back results sum=i-1 mod 2^28 (cout=1 for i>=1), no bubbles.
REQ-033 Backpressure: 4 inputs streamed, out_ready=0 for 5 cycles -> in_ready falls after 2 accepts, outputs held stable, then all 4 results emerge in order once out_ready=1.
REQ-034 Reset mid-stream: rst asserted with both stages full -> next cycle out_valid=0, in_ready=1; flushed operands never appear.
REQ-035 With CLA28_PIPE_CHECK_EN, 1000 random operand sets -> err stays 0; forcing a corrupted stage-2 sum -> err=1 and remains set until rst.
